bit_unpacker_stream: RTL and testbench
======================================

Name: bit_unpacker_stream

Overview:
- Parametrised successor to the fixed 16-bit extractor ring.
- Unpacks a dense, LSB-first bitstream of IN_WIDTH-bit words into individual values of runtime-selectable bitwidth, with optional sign extension to OUT_WIDTH.
- Sits between the memory-read stream and the dequantisation datapath.
- Adds over the previous generation:
  - explicit start/done run control;
  - exact input-word accounting, so trailing words are never over-consumed;
  - ready-independent trm_valid;
  - configuration error detection.

Parameters:
IN_WIDTH, 16, width of packed input words (power of two, >= OUT_WIDTH)
OUT_WIDTH, 16, width of extracted output values; maximum supported bitwidth
BW_WIDTH, 5, width of bitwidth field; must hold OUT_WIDTH
CNT_WIDTH, 32, width of value counters

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; latches config and begins a run (honoured in IDLE/DONE only)
bitwidth  in  BW_WIDTH  bits per value, legal 1..OUT_WIDTH
sign_extend  in  1  1: sign-extend value to OUT_WIDTH; 0: zero-extend
num_of_vals  in  CNT_WIDTH  values to extract in this run
rcv_valid  in  1  input word valid
rcv_data  in  IN_WIDTH  packed input word
rcv_ready  out  1  input word accepted when rcv_valid & rcv_ready
trm_valid  out  1  output value valid
trm_data  out  OUT_WIDTH  extracted value
trm_ready  in  1  downstream accepts value
busy  out  1  run in progress
done  out  1  run complete; sticky until next start or reset
err  out  1  last start had illegal bitwidth; sticky until next start or reset
transmitted_values  out  CNT_WIDTH  values handed over in current run

Behaviour:
- Reset (rstn=0 at clk edge), mid-run included:
  - state=IDLE; buffer, fill, counters cleared.
  - All outputs 0 (rcv_ready, trm_valid, trm_data, busy, done, err, transmitted_values).
  - Partially consumed data is discarded.
- States: IDLE, RUN, DONE.
- On start in IDLE or DONE:
  - Latch bitwidth, sign_extend, num_of_vals.
  - Compute total_bits = num_of_vals*bitwidth (registered; width CNT_WIDTH+BW_WIDTH).
  - Clear transmitted_values, bits_accepted, fill, done, err.
  - bitwidth==0 or >OUT_WIDTH: err=1, go DONE next cycle.
  - Else num_of_vals==0: go DONE next cycle.
  - Else go RUN.
  - start while in RUN is ignored.
- Buffer: 2*IN_WIDTH bits plus fill counter (0..2*IN_WIDTH). Valid bits occupy [fill-1:0]; bit 0 is the next value's LSB.
- rcv_ready = (state==RUN) & (fill - (emit ? bw : 0) <= IN_WIDTH) & (bits_accepted < total_bits).
  - rcv_ready must not depend on rcv_valid.
  - Each accepted word is written at position fill (or fill-bw when emitting the same cycle).
  - bits_accepted += IN_WIDTH on each accepted word.
- trm_valid = (state==RUN) & (fill >= bw).
  - trm_valid must not depend on trm_ready.
  - Once asserted, trm_valid and trm_data stay stable until trm_ready.
- Output data:
  - trm_data[bw-1:0] = buffer[bw-1:0].
  - Upper bits = buffer[bw-1] when sign_extend=1, else 0.
- emit = trm_valid & trm_ready. On emit:
  - buffer shifts right by bw;
  - fill -= bw;
  - transmitted_values += 1.
- Simultaneous accept and emit: fill_next = fill - bw + IN_WIDTH.
  - Throughput: 1 value/cycle sustained.
  - Values straddling a word boundary are supported without a bubble.
- Latency: word accepted at edge t → first value from it has trm_valid in cycle t+1.
- Run completion:
  - When transmitted_values reaches num_of_vals on an emit, go DONE next cycle; done=1, busy=0.
  - Padding bits remaining in the buffer are discarded.
  - No word beyond ceil(total_bits/IN_WIDTH) is ever accepted.
- busy=1 exactly in RUN.
- trm_data holds its last value outside RUN.
- Counters never wrap within legal configs; num_of_vals*bitwidth must not overflow the total_bits width.

Test Plan:
1. IN=16, bw=4, unsigned, num=4, one word 0x4321, trm_ready=1 → trm_data 0x0001,0x0002,0x0003,0x0004 on consecutive cycles; exactly 1 word accepted; rcv_ready low afterwards; done=1, transmitted_values=4.
2. bw=5, signed, num=4, words 0x0FE1, 0x0008 → outputs 0x0001, 0xFFFF, 0x0003, 0xFFF0 (the last straddles both words); exactly 2 words accepted, with a third word offered and not taken.
3. bw=3, num=10, trm_ready low 5 cycles mid-run → trm_valid stays 1, trm_data stable; rcv_ready deasserts once fill > IN_WIDTH; all 10 values correct, none lost or duplicated.
4. bw=16, num=8, rcv_valid and trm_ready constantly 1 → 8 values in 8 consecutive cycles after 1-cycle latency; each trm_data equals its input word.
5. start with bitwidth=0 → err=1, done=1 next cycle, no rcv_ready. start with num=0 → done=1, err=0, no words taken.
6. rstn=0 for one cycle after 2 of 6 values (bw=7), then new start with bw=4, num=2, word 0x00A5 → all outputs 0 during reset; outputs 0x0005, 0x000A; no stale bits from the aborted run.

Source files
------------

// File: rtl/bit_unpacker_stream.sv
// bit_unpacker_stream
// ---------------------------------------------------------------------------
// Unpacks a dense, LSB-first bitstream of IN_WIDTH-bit words into values of
// runtime-selectable bitwidth (1..OUT_WIDTH). Each value is either
// sign-extended or zero-extended to OUT_WIDTH. A run is launched with a
// one-cycle start pulse that latches the configuration. The run ends after
// num_of_vals values have been handed downstream. Input words are counted
// exactly, so no word beyond ceil(num_of_vals*bitwidth/IN_WIDTH) is taken.
//
// Ports
//   clk                 clock
//   rstn                synchronous active-low reset
//   start               run launch pulse (honoured in IDLE/DONE only)
//   bitwidth            bits per value for the run, legal 1..OUT_WIDTH
//   sign_extend         1: sign-extend value, 0: zero-extend
//   num_of_vals         number of values to extract in the run
//   rcv_valid/rcv_data  packed input word stream
//   rcv_ready           input word accepted when rcv_valid & rcv_ready
//   trm_valid/trm_data  extracted value stream
//   trm_ready           downstream accepts value
//   busy                run in progress
//   done                run complete (sticky until next start/reset)
//   err                 last start carried an illegal bitwidth (sticky)
//   transmitted_values  values handed over in the current run
// ---------------------------------------------------------------------------
module bit_unpacker_stream #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int BW_WIDTH  = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [BW_WIDTH-1:0]  bitwidth,
  input  logic                 sign_extend,
  input  logic [CNT_WIDTH-1:0] num_of_vals,
  input  logic                 rcv_valid,
  input  logic [IN_WIDTH-1:0]  rcv_data,
  output logic                 rcv_ready,
  output logic                 trm_valid,
  output logic [OUT_WIDTH-1:0] trm_data,
  input  logic                 trm_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] transmitted_values
);

  localparam int BUF_W  = 2 * IN_WIDTH;
  localparam int FILL_W = $clog2(BUF_W) + 1;
  localparam int TOT_W  = CNT_WIDTH + BW_WIDTH;
  // One spare bit: the last accepted word may carry the count past total_bits.
  localparam int ACC_W  = TOT_W + 1;

  localparam logic [FILL_W-1:0]   IN_W_F = FILL_W'(IN_WIDTH);
  localparam logic [BW_WIDTH-1:0] MAX_BW = BW_WIDTH'(OUT_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Takes the low bw bits of the buffer head and extends them to OUT_WIDTH.
  function automatic logic [OUT_WIDTH-1:0] f_extract(
    input logic [OUT_WIDTH-1:0] head,
    input logic [BW_WIDTH-1:0]  bw,
    input logic                 sext
  );
    logic [OUT_WIDTH-1:0] mask;
    logic [OUT_WIDTH-1:0] raw;
    logic                 sbit;
    mask = ~({OUT_WIDTH{1'b1}} << bw);
    raw  = head & mask;
    // mask >> 1 covers bits below the MSB of the field, so what survives the
    // inverted mask is the field MSB alone.
    sbit = |(raw & ~(mask >> 1));
    if (sext && sbit) begin
      f_extract = raw | ~mask;
    end else begin
      f_extract = raw;
    end
  endfunction

  // Control and datapath state
  state_t               r_state;
  logic [BW_WIDTH-1:0]  r_bw;
  logic                 r_sext;
  logic [CNT_WIDTH-1:0] r_num;
  logic [TOT_W-1:0]     r_total_bits;
  logic [ACC_W-1:0]     r_bits_acc;
  logic [BUF_W-1:0]     r_buf;
  logic [FILL_W-1:0]    r_fill;
  logic [CNT_WIDTH-1:0] r_tx;
  logic                 r_err;
  logic [OUT_WIDTH-1:0] r_trm_data;

  // Next-state and combinational datapath
  state_t               w_state_next;
  logic [FILL_W-1:0]    w_bw_f;
  logic                 w_cfg_bad;
  logic                 w_start_ok;
  logic                 w_trm_valid;
  logic                 w_emit;
  logic [FILL_W-1:0]    w_base;
  logic                 w_rcv_ready;
  logic                 w_accept;
  logic [BUF_W-1:0]     w_shifted;
  logic [BUF_W-1:0]     w_keep;
  logic [BUF_W-1:0]     w_buf_next;
  logic [FILL_W-1:0]    w_fill_next;
  logic [CNT_WIDTH-1:0] w_tx_next;
  logic                 w_last;

  always_comb begin
    w_state_next = r_state;
    w_bw_f       = FILL_W'(r_bw);
    w_cfg_bad    = (bitwidth == '0) || (bitwidth > MAX_BW);
    w_start_ok   = start && (r_state != S_RUN);

    w_trm_valid  = (r_state == S_RUN) && (r_fill >= w_bw_f);
    w_emit       = w_trm_valid && trm_ready;

    // Write position for an incoming word: the fill level after this
    // cycle's emit has removed its bits.
    w_base       = w_emit ? (r_fill - w_bw_f) : r_fill;
    w_rcv_ready  = (r_state == S_RUN) && (w_base <= IN_W_F) &&
                   (r_bits_acc < ACC_W'(r_total_bits));
    w_accept     = w_rcv_ready && rcv_valid;

    w_shifted    = w_emit ? (r_buf >> r_bw) : r_buf;
    // Clear everything from the write position upward before merging, so the
    // new word never ORs into leftover bits.
    w_keep       = ~({BUF_W{1'b1}} << w_base);
    w_buf_next   = w_accept ? ((w_shifted & w_keep) | (BUF_W'(rcv_data) << w_base))
                            : w_shifted;
    w_fill_next  = w_accept ? (w_base + IN_W_F) : w_base;

    w_tx_next    = w_emit ? (r_tx + CNT_WIDTH'(1)) : r_tx;
    w_last       = w_emit && (w_tx_next == r_num);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = (w_cfg_bad || (num_of_vals == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_bw         <= '0;
      r_sext       <= 1'b0;
      r_num        <= '0;
      r_total_bits <= '0;
      r_bits_acc   <= '0;
      r_buf        <= '0;
      r_fill       <= '0;
      r_tx         <= '0;
      r_err        <= 1'b0;
      r_trm_data   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_ok) begin
        r_bw         <= bitwidth;
        r_sext       <= sign_extend;
        r_num        <= num_of_vals;
        r_total_bits <= TOT_W'(num_of_vals) * TOT_W'(bitwidth);
        r_bits_acc   <= '0;
        r_buf        <= '0;
        r_fill       <= '0;
        r_tx         <= '0;
        r_err        <= w_cfg_bad;
      end else if (r_state == S_RUN) begin
        r_buf  <= w_buf_next;
        r_fill <= w_fill_next;
        r_tx   <= w_tx_next;
        if (w_accept) begin
          r_bits_acc <= r_bits_acc + ACC_W'(IN_WIDTH);
        end
        // The output value is registered from the next buffer head. Updating
        // only while the run continues with a full value in hand keeps the
        // last emitted value on trm_data after the run ends.
        if ((w_state_next == S_RUN) && (w_fill_next >= w_bw_f)) begin
          r_trm_data <= f_extract(w_buf_next[OUT_WIDTH-1:0], r_bw, r_sext);
        end
      end
    end
  end

  assign rcv_ready          = w_rcv_ready;
  assign trm_valid          = w_trm_valid;
  assign trm_data           = r_trm_data;
  assign busy               = (r_state == S_RUN);
  assign done               = (r_state == S_DONE);
  assign err                = r_err;
  assign transmitted_values = r_tx;

endmodule

// File: tb/tb_bit_unpacker_stream.sv
module tb_bit_unpacker_stream;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [4:0]  bitwidth;
  logic        sign_extend;
  logic [31:0] num_of_vals;
  logic        rcv_valid;
  logic [15:0] rcv_data;
  logic        rcv_ready;
  logic        trm_valid;
  logic [15:0] trm_data;
  logic        trm_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] transmitted_values;

  int checks = 0;
  int errors = 0;
  int words_acc = 0;

  logic [15:0] wq[$];  // words still to offer
  logic [15:0] sb[$];  // expected output values

  bit_unpacker_stream #(
    .IN_WIDTH(16), .OUT_WIDTH(16), .BW_WIDTH(5), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .bitwidth(bitwidth),
    .sign_extend(sign_extend), .num_of_vals(num_of_vals),
    .rcv_valid(rcv_valid), .rcv_data(rcv_data), .rcv_ready(rcv_ready),
    .trm_valid(trm_valid), .trm_data(trm_data), .trm_ready(trm_ready),
    .busy(busy), .done(done), .err(err),
    .transmitted_values(transmitted_values)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: concatenates the queued words LSB-first and slices
  // num values of bw bits, extending each to 16 bits.
  task automatic model(input int bw, input bit sx, input int num);
    bit bits[$];
    logic [15:0] v;
    foreach (wq[i]) for (int b = 0; b < 16; b++) bits.push_back(wq[i][b]);
    for (int k = 0; k < num; k++) begin
      v = '0;
      for (int b = 0; b < 16; b++) begin
        if (b < bw) v[b] = bits[k*bw + b];
        else        v[b] = sx ? bits[k*bw + bw - 1] : 1'b0;
      end
      sb.push_back(v);
    end
  endtask

  task automatic do_start(input int bw, input bit sx, input int num);
    bitwidth    = 5'(bw);
    sign_extend = sx;
    num_of_vals = 32'(num);
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // Offers words from wq, compares emitted values against sb, optionally
  // stalls trm_ready, and stops on done, after stop_emits values, or budget.
  task automatic run(input int budget, input int stall_from, input int stall_len,
                     input int stop_emits, output int acc0, output int em0, output int emn);
    int  c;
    int  ne;
    bit  acc;
    bit  em;
    bit  fin;
    logic [15:0] exp_v;
    c = 0; ne = 0; fin = 0;
    acc0 = -1; em0 = -1; emn = -1;
    while (c < budget && !fin) begin
      rcv_valid = (wq.size() > 0);
      rcv_data  = (wq.size() > 0) ? wq[0] : 16'h0;
      trm_ready = !((c >= stall_from) && (c < stall_from + stall_len));
      @(negedge clk);
      acc = rcv_valid && rcv_ready;
      em  = trm_valid && trm_ready;
      if (acc) begin
        words_acc++;
        if (acc0 < 0) acc0 = c;
      end
      if (!trm_ready) begin
        chk("stall_valid", trm_valid, 1'b1);
        chk("stall_rdy", rcv_ready, 1'b0);
        if (sb.size() > 0) chk("stall_data", trm_data, sb[0]);
      end
      if (em) begin
        chk("sb_nonempty", (sb.size() > 0), 1'b1);
        if (sb.size() > 0) begin
          exp_v = sb.pop_front();
          chk("value", trm_data, exp_v);
        end
        ne++;
        if (em0 < 0) em0 = c;
        emn = c;
      end
      @(posedge clk);
      #1;
      if (acc) void'(wq.pop_front());
      c++;
      if (done || (stop_emits > 0 && ne >= stop_emits)) fin = 1;
    end
    chk("run_in_budget", fin, 1'b1);
    rcv_valid = 1'b0;
    trm_ready = 1'b1;
  endtask

  task automatic offer(input int n, output int acc);
    acc = 0;
    rcv_valid = 1'b1;
    rcv_data  = 16'hFFFF;
    repeat (n) begin
      @(negedge clk);
      if (rcv_ready) acc++;
      @(posedge clk);
      #1;
    end
    rcv_valid = 1'b0;
  endtask

  initial begin
    int a0, e0, en, w0, nacc;
    rstn = 1'b0; start = 1'b0; bitwidth = '0; sign_extend = 1'b0;
    num_of_vals = '0; rcv_valid = 1'b0; rcv_data = '0; trm_ready = 1'b1;
    tick(); tick();
    chk("rst_rcv_ready", rcv_ready, 1'b0);
    chk("rst_trm_valid", trm_valid, 1'b0);
    chk("rst_trm_data", trm_data, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_tx", transmitted_values, 32'h0);
    rstn = 1'b1;
    tick();

    // 1: bw=4 unsigned, one word
    wq = '{16'h4321};
    model(4, 0, 4);
    w0 = words_acc;
    do_start(4, 0, 4);
    chk("t1_busy", busy, 1'b1);
    run(50, 0, 0, 0, a0, e0, en);
    chk("t1_words", words_acc - w0, 1);
    chk("t1_done", done, 1'b1);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_tx", transmitted_values, 32'd4);
    chk("t1_rdy_after", rcv_ready, 1'b0);
    chk("t1_last", trm_data, 16'h0004);
    chk("t1_latency", e0, a0 + 1);
    chk("t1_consecutive", en - e0, 3);
    chk("t1_sb_empty", sb.size(), 0);

    // 2: bw=5 signed, straddling value, third word must not be taken
    wq = '{16'h0FE1, 16'h0008, 16'hBEEF};
    model(5, 1, 4);
    w0 = words_acc;
    do_start(5, 1, 4);
    run(50, 0, 0, 0, a0, e0, en);
    chk("t2_words", words_acc - w0, 2);
    chk("t2_left", wq.size(), 1);
    chk("t2_tx", transmitted_values, 32'd4);
    chk("t2_last", trm_data, 16'hFFF0);
    chk("t2_err", err, 1'b0);
    wq.delete();

    // 3: bw=3, downstream stall mid-run
    wq = '{16'hB6D3, 16'h5A17};
    model(3, 0, 10);
    w0 = words_acc;
    do_start(3, 0, 10);
    run(100, 4, 5, 0, a0, e0, en);
    chk("t3_words", words_acc - w0, 2);
    chk("t3_tx", transmitted_values, 32'd10);
    chk("t3_sb_empty", sb.size(), 0);

    // 4: bw=16 full-rate streaming
    for (int i = 0; i < 8; i++) wq.push_back(16'($urandom));
    model(16, 1, 8);
    w0 = words_acc;
    do_start(16, 1, 8);
    run(100, 0, 0, 0, a0, e0, en);
    chk("t4_words", words_acc - w0, 8);
    chk("t4_latency", e0, a0 + 1);
    chk("t4_consecutive", en - e0, 7);
    chk("t4_tx", transmitted_values, 32'd8);

    // 5: illegal bitwidth, then zero-length run
    do_start(0, 0, 5);
    chk("t5_err", err, 1'b1);
    chk("t5_done", done, 1'b1);
    chk("t5_busy", busy, 1'b0);
    offer(3, nacc);
    chk("t5_no_words", nacc, 0);
    do_start(4, 0, 0);
    chk("t5z_err", err, 1'b0);
    chk("t5z_done", done, 1'b1);
    offer(3, nacc);
    chk("t5z_no_words", nacc, 0);
    do_start(17, 0, 3);
    chk("t5o_err", err, 1'b1);

    // 6: reset mid-run, then a clean run
    for (int i = 0; i < 3; i++) wq.push_back(16'($urandom));
    model(7, 0, 6);
    do_start(7, 0, 6);
    run(50, 0, 0, 2, a0, e0, en);
    chk("t6_tx_mid", transmitted_values, 32'd2);
    rstn = 1'b0;
    tick();
    chk("t6_rst_rcv_ready", rcv_ready, 1'b0);
    chk("t6_rst_trm_valid", trm_valid, 1'b0);
    chk("t6_rst_trm_data", trm_data, 16'h0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_err", err, 1'b0);
    chk("t6_rst_tx", transmitted_values, 32'h0);
    rstn = 1'b1;
    sb.delete();
    wq.delete();
    wq = '{16'h00A5};
    model(4, 0, 2);
    do_start(4, 0, 2);
    run(50, 0, 0, 0, a0, e0, en);
    chk("t6_tx", transmitted_values, 32'd2);
    chk("t6_done", done, 1'b1);
    chk("t6_last", trm_data, 16'h000A);
    chk("t6_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
